// File: rtl/chan_select_writer.sv
// Channelizer down-select mask writer.
// Holds the per-bin enable mask and streams it on commit or FFT size change.
module chan_select_writer #(
  parameter int FFT_SIZE_WIDTH = 12,
  parameter int MAX_WORDS      = 64,
  parameter int ADDR_WIDTH     = 6
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic                      cfg_wr_en,
  input  logic [ADDR_WIDTH-1:0]     cfg_wr_addr,
  input  logic [31:0]               cfg_wr_data,
  output logic                      cfg_wr_err,
  input  logic                      commit,
  input  logic [FFT_SIZE_WIDTH-1:0] fft_size,
  output logic                      busy,
  output logic                      m_axis_select_tvalid,
  output logic [31:0]               m_axis_select_tdata,
  output logic                      m_axis_select_tlast,
  input  logic                      m_axis_select_tready
);

  localparam int NW_W = ADDR_WIDTH + 1;
  localparam logic [FFT_SIZE_WIDTH-1:0] SZ_MIN = FFT_SIZE_WIDTH'(8);
  localparam logic [FFT_SIZE_WIDTH-1:0] SZ_32  = FFT_SIZE_WIDTH'(32);
  localparam logic [FFT_SIZE_WIDTH-1:0] SZ_MAX = FFT_SIZE_WIDTH'(MAX_WORDS * 32);
  localparam logic [FFT_SIZE_WIDTH-1:0] SZ_RST = FFT_SIZE_WIDTH'(128);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t                    state_q, state_d;
  logic [31:0]               mask_q [MAX_WORDS];
  logic [ADDR_WIDTH-1:0]     idx_q, idx_d;
  logic [FFT_SIZE_WIDTH-1:0] size_q, size_d;
  logic [FFT_SIZE_WIDTH-1:0] size_l_q, size_l_d;
  logic [NW_W-1:0]           nw_q, nw_d;
  logic                      pend_q, pend_d;
  logic                      busy_q, busy_d;
  logic                      err_q, err_d;
  logic                      tvalid_q, tvalid_d;
  logic                      tlast_q, tlast_d;
  logic [31:0]               tdata_q, tdata_d;

  logic                      size_chg, req;
  logic [FFT_SIZE_WIDTH-1:0] new_size;
  logic [NW_W-1:0]           new_nw;
  logic [ADDR_WIDTH-1:0]     idx_nx;
  logic [31:0]               keep, cur_word, nxt_word;
  logic                      cur_last, nxt_last, hs;

  // Sizes other than a power of two in 8..1024 fall back to the full 2048.
  function automatic logic [FFT_SIZE_WIDTH-1:0] dec_size(
    input logic [FFT_SIZE_WIDTH-1:0] s
  );
    logic pow2;
    pow2 = (s & (s - FFT_SIZE_WIDTH'(1))) == '0;
    if (pow2 && s >= SZ_MIN && s < SZ_MAX) return s;
    return SZ_MAX;
  endfunction

  // Mask storage; writes are only accepted while not streaming.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < MAX_WORDS; i++) mask_q[i] <= '0;
    end else if (cfg_wr_en && !busy_q) begin
      mask_q[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  // Request detection, word fetch and size decode.
  always_comb begin
    size_chg = (fft_size != '0) && (fft_size != size_l_q);
    req      = commit | size_chg;
    new_size = dec_size(fft_size);
    new_nw   = (new_size < SZ_32) ? NW_W'(1) : NW_W'(new_size >> 5);
    idx_nx   = idx_q + ADDR_WIDTH'(1);
    keep     = (size_q < SZ_32) ? ~(32'hFFFF_FFFF << size_q[4:0]) : '1;
    cur_word = mask_q[idx_q] & keep;
    nxt_word = mask_q[idx_nx] & keep;
    cur_last = {1'b0, idx_q} == (nw_q - NW_W'(1));
    nxt_last = {1'b0, idx_nx} == (nw_q - NW_W'(1));
    hs       = tvalid_q & m_axis_select_tready;
  end

  // Next-state logic for the stream FSM and its datapath.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    size_d   = size_q;
    nw_d     = nw_q;
    pend_d   = pend_q;
    busy_d   = busy_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    size_l_d = size_chg ? fft_size : size_l_q;
    err_d    = cfg_wr_en & busy_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          size_d  = new_size;
          nw_d    = new_nw;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (req) pend_d = 1'b1;
        tdata_d  = cur_word;
        tvalid_d = 1'b1;
        tlast_d  = cur_last;
        state_d  = SEND;
      end
      SEND: begin
        if (req) pend_d = 1'b1;
        if (hs && !tlast_q) begin
          idx_d   = idx_nx;
          tdata_d = nxt_word;
          tlast_d = nxt_last;
        end else if (hs) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          if (pend_q || req) begin
            pend_d  = 1'b0;
            size_d  = new_size;
            nw_d    = new_nw;
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      size_q   <= SZ_RST;
      size_l_q <= SZ_RST;
      nw_q     <= NW_W'(4);
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      size_q   <= size_d;
      size_l_q <= size_l_d;
      nw_q     <= nw_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
    end
  end

  assign cfg_wr_err           = err_q;
  assign busy                 = busy_q;
  assign m_axis_select_tvalid = tvalid_q;
  assign m_axis_select_tdata  = tdata_q;
  assign m_axis_select_tlast  = tlast_q;

endmodule

// File: doc/chan_select_writer.md
Name: chan_select_writer

Overview:
- Producer side of the channelizer down-select FIFO interface (s_axis_select_*).
- Holds a host-written per-bin enable mask and streams it as packed 32-bit words on commit. The final word is tagged with tlast.
- Sits between the control/register domain and the channelizer; runs on the same clock.
- Also re-issues the mask automatically whenever the channelizer FFT size changes, so a channelizer reconfiguration never leaves the select FIFO stale.

Parameters:
- FFT_SIZE_WIDTH, 12, width of fft_size input.
- MAX_WORDS, 64, mask depth in 32-bit words (2048 bins / 32).
- ADDR_WIDTH, 6, clog2(MAX_WORDS).

Ports:
- clk  in  1  clock.
- aresetn  in  1  reset, asynchronous assert, active-low.
- cfg_wr_en  in  1  mask word write strobe.
- cfg_wr_addr  in  ADDR_WIDTH  mask word index; bit b of word w enables bin 32*w+b.
- cfg_wr_data  in  32  mask word data.
- cfg_wr_err  out  1  one-cycle pulse: write dropped because busy.
- commit  in  1  request to stream the current mask.
- fft_size  in  FFT_SIZE_WIDTH  channelizer FFT size (8..2048).
- busy  out  1  high from commit acceptance until the last word handshake.
- m_axis_select_tvalid  out  1  select stream valid.
- m_axis_select_tdata  out  32  mask word.
- m_axis_select_tlast  out  1  final word of mask.
- m_axis_select_tready  in  1  downstream ready.

Behaviour:
- Reset (aresetn low, asynchronous): tvalid=0, tdata=0, tlast=0, busy=0, cfg_wr_err=0; all mask words=0; pending=0; size_l=128; state=IDLE. Asserting reset mid-stream drops tvalid immediately with no tlast. After release, no stream is emitted until a commit or fft_size change.
- Size decode: fft_size in {8,16,...,1024} is used as-is; any other value decodes to 2048.
  - nwords = 1 when the size is below 32, else size>>5.
  - Word 0 bits at or above size are forced to 0 when size is below 32.
- Writes: when busy=0, cfg_wr_en updates mask[cfg_wr_addr] at the edge. When busy=1 the write is dropped and cfg_wr_err pulses the next cycle.
- Commit sources:
  - the commit input;
  - fft_size nonzero and different from size_l, sampled each cycle. This updates size_l.
- FSM IDLE -> LOAD -> SEND -> IDLE:
  - IDLE: on any commit source, latch the decoded size and nwords, set busy=1, idx=0, go to LOAD.
  - LOAD (1 cycle): register mask[idx] (masked) into tdata, tvalid=1, tlast=(idx==nwords-1), go to SEND.
  - SEND: tdata, tvalid and tlast are held stable while tready=0.
    - On handshake with tlast=0: idx+1, load the next word in the same edge. Back-to-back is 1 word/cycle with no bubble.
    - On handshake with tlast=1: tvalid=0, tlast=0. If pending=1, clear pending and go to LOAD with the new size. Otherwise busy=0 and go to IDLE.
- Latency: commit sampled at edge N gives tvalid=1 after edge N+1.
- Commit source while busy sets pending (depth 1; repeats coalesce). Commit and fft_size change in the same cycle count as one request.
- cfg_wr_en together with commit in IDLE: the write lands first, and the stream carries the new data.
- idx never exceeds nwords-1. Words beyond nwords are never emitted.

Test Plan:
- Reset release with fft_size=128, write words0..3=0xF0000001,0,0,0x80000000, commit, tready=1 -> 4 words on consecutive cycles, tlast on 4th, tvalid asserted 2 edges after commit, busy falls after the last handshake.
- fft_size=8, word0=0xFFFFFFFF, commit -> single word 0x000000FF with tlast=1.
- fft_size=2048, tready toggled randomly -> exactly 64 words, data stable under stall, tlast only on word 63.
- Commit and cfg_wr_en during SEND -> cfg_wr_err pulses, mask unchanged, second full stream follows immediately after the first tlast.
- fft_size changes 128->512 while idle, no commit -> 16-word stream emitted automatically. fft_size=1000 -> 64 words.
- aresetn low mid-stream at word 2 -> tvalid=0 the same cycle, no tlast; after release, no output until commit, and the mask reads back all zeros.
